jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
- Upstream driver stage for the JK flip-flop: accepts SET/RESET/TOGGLE/HOLD commands with repeat counts and buffers them in a small FIFO.
- Plays each command out as registered J/K levels, one flop sample per cycle.
- Tracks the expected flop state and compares it against the flop's Q fed back, flagging any divergence.
- Replaces hand-written J/K stimulus in flop benches and board-level test harnesses.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- CNT_W, 4, repeat-count width; a command is applied for CMD_CNT+1 consecutive cycles.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RST_N  input  1  synchronous, active-low reset, sampled on posedge CLK.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  FIFO can accept; equals !full.
- CMD_OP  input  2  command opcode: 00 HOLD (J=0,K=0), 01 RESET (J=0,K=1), 10 SET (J=1,K=0), 11 TOGGLE (J=1,K=1).
- CMD_CNT  input  CNT_W  repeat count minus one.
- J  output  1  registered J drive to the flop.
- K  output  1  registered K drive to the flop.
- Q_FB  input  1  Q from the driven flop.
- BUSY  output  1  FSM in EXEC or FIFO non-empty.
- DONE  output  1  one-cycle pulse on the final cycle of each command's playout.
- EXP_Q  output  1  model of the flop's Q.
- MISMATCH  output  1  sticky compare error.

Behaviour:
- Reset (RST_N=0 at posedge) is synchronous and active-low:
  - Flushes the FIFO and forces the FSM to IDLE.
  - Drives J=0, K=0, BUSY=0, DONE=0, EXP_Q=0, MISMATCH=0, and clears the internal KNOWN flag.
  - Reset mid-command abandons that command and every queued command; no DONE is produced.
- Handshake:
  - A command is pushed at a posedge where CMD_VALID && CMD_READY.
  - CMD_READY = !full, combinational from the FIFO pointers only.
  - A pop in the same cycle does not make a full FIFO ready.
  - CMD_OP and CMD_CNT are ignored when no push occurs.
- FIFO: pointers carry one extra wrap bit. Full when the indices are equal and the wrap bits differ; empty when pointers are equal.
- FSM has two states, IDLE and EXEC:
  - IDLE: J=K=0. If the FIFO is non-empty, pop the head entry, load J/K from the opcode, load the remaining count with CMD_CNT, and go to EXEC.
  - EXEC: hold J/K. While the remaining count is non-zero, decrement it each cycle.
  - When the remaining count is 0, that cycle is the final one and DONE=1. At the next edge:
    - if the FIFO is non-empty, pop the next command with no gap cycle (J/K change directly to the new opcode);
    - otherwise go to IDLE with J=K=0.
- Latency:
  - Command pushed into an empty, idle block at edge n: J/K take the opcode value after edge n+1.
  - A command with CMD_CNT=c holds J/K for exactly c+1 cycles.
- Expected-state model:
  - At every posedge (not in reset), EXP_Q updates from the current J/K, the same values the flop samples at that edge:
    - 00 keeps EXP_Q;
    - 01 gives 0;
    - 10 gives 1;
    - 11 gives ~EXP_Q.
  - KNOWN is set the first time 01 or 10 is applied. It stays 0 under 00 and 11 while unknown.
- Compare: at each posedge where KNOWN was already 1 before that edge, if Q_FB != EXP_Q then MISMATCH is set. MISMATCH clears only on reset.
- BUSY = (state==EXEC) || !empty.

Optional Feature:
- Macro: JK_SEQ_CHECK_EN.
- Defined: the EXP_Q model, the KNOWN flag and the MISMATCH compare are built as described in Behaviour.
- Undefined: that logic is not built. EXP_Q and MISMATCH are tied to 0 and Q_FB is unused. FIFO, FSM, J/K and DONE behaviour are unchanged.

Test Plan:
- Reset then single push, OP=10, CNT=0 at edge n: J=1,K=0 for exactly one cycle after edge n+1; DONE=1 that cycle; then J=K=0, BUSY=0, EXP_Q=1, MISMATCH=0 against a correct flop.
- Push OP=11 CNT=3 after a SET: J=K=1 for 4 cycles; EXP_Q toggles 1→0→1→0→1; a correct flop keeps MISMATCH=0.
- Hold CMD_VALID high with 6 commands while the FSM is busy, DEPTH=4: CMD_READY drops to 0 after 4 accepted pushes; all 6 commands play out in order with no gap cycles; 6 DONE pulses.
- Push OP=01 CNT=2 against a flop stuck at Q=1: MISMATCH rises one edge after the first RESET sample and stays 1 through later correct cycles until RST_N=0.
- Assert RST_N=0 for one edge mid-TOGGLE with 2 commands queued: next cycle J=K=0, BUSY=0, CMD_READY=1, EXP_Q=0, MISMATCH=0; queued commands are never driven.
- Apply only TOGGLE/HOLD after reset with a random Q_FB: MISMATCH stays 0 (KNOWN=0) until the first SET/RESET. Rerun the full bench without JK_SEQ_CHECK_EN: MISMATCH=0 and EXP_Q=0 throughout.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO and two-state player that drives registered J/K levels into a JK flop.
// Define JK_SEQ_CHECK_EN to build the expected-Q model and the sticky Q_FB compare.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_CNT,
    output logic             J,
    output logic             K,
    input  logic             Q_FB,
    output logic             BUSY,
    output logic             DONE,
    output logic             EXP_Q,
    output logic             MISMATCH
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    typedef struct packed {
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
    } cmd_t;

    cmd_t             fifo_mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    cmd_t             head;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d, k_q, k_d;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = CMD_VALID && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    // NOTE: storage is not reset; entries are only ever read behind a valid write pointer.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {CMD_OP, CMD_CNT};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_d    = S_EXEC;
                    {j_d, k_d} = head.op;
                    cnt_d      = head.cnt;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!fifo_empty) begin
                    // Chain straight into the next command without an idle cycle.
                    pop        = 1'b1;
                    {j_d, k_d} = head.op;
                    cnt_d      = head.cnt;
                end else begin
                    state_d = S_IDLE;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
            end
        endcase
    end

    always_comb begin
        CMD_READY = !fifo_full;
        J         = j_q;
        K         = k_q;
        DONE      = (state_q == S_EXEC) && (cnt_q == '0);
        BUSY      = (state_q == S_EXEC) || !fifo_empty;
    end

`ifdef JK_SEQ_CHECK_EN
    logic exp_q, known_q, mismatch_q;

    // The model updates from the same J/K the flop samples at this edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            exp_q      <= 1'b0;
            known_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            case ({j_q, k_q})
                2'b01:   exp_q <= 1'b0;
                2'b10:   exp_q <= 1'b1;
                2'b11:   exp_q <= ~exp_q;
                default: exp_q <= exp_q;
            endcase
            if (j_q ^ k_q) known_q <= 1'b1;
            if (known_q && (Q_FB != exp_q)) mismatch_q <= 1'b1;
        end
    end

    assign EXP_Q    = exp_q;
    assign MISMATCH = mismatch_q;
`else
    logic unused_q_fb;

    assign unused_q_fb = Q_FB;
    assign EXP_Q       = 1'b0;
    assign MISMATCH    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: playout timing, FIFO backpressure, reset and Q compare.
// Expectations for EXP_Q/MISMATCH follow whether JK_SEQ_CHECK_EN is defined.
module tb_jk_cmd_sequencer;

    localparam int CNT_W = 4;
`ifdef JK_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [1:0]       CMD_OP = 2'b00;
    logic [CNT_W-1:0] CMD_CNT = '0;
    logic             J, K, BUSY, DONE, EXP_Q, MISMATCH;
    logic             Q_FB;

    logic       flop_q = 1'b0;
    logic [1:0] q_mode = 2'd0;  // 0: real flop, 1: stuck at 1, 2: random
    logic       rnd_q  = 1'b0;
    int         n_cmp  = 0;
    int         n_err  = 0;

    jk_cmd_sequencer #(.DEPTH(4), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_CNT   (CMD_CNT),
        .J         (J),
        .K         (K),
        .Q_FB      (Q_FB),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .EXP_Q     (EXP_Q),
        .MISMATCH  (MISMATCH)
    );

    always #5 CLK = ~CLK;

    // Behavioural JK flop driven by the DUT.
    always @(posedge CLK) begin
        case ({J, K})
            2'b01:   flop_q <= 1'b0;
            2'b10:   flop_q <= 1'b1;
            2'b11:   flop_q <= ~flop_q;
            default: flop_q <= flop_q;
        endcase
    end

    assign Q_FB = (q_mode == 2'd1) ? 1'b1 : (q_mode == 2'd2) ? rnd_q : flop_q;

    task automatic step();
        @(posedge CLK);
        #1;
        rnd_q = 1'($urandom_range(0, 1));
    endtask

    task automatic push_one(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_CNT   = cnt;
        step();
        CMD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        step();
        step();
        n_cmp++;
        if ({J, K, DONE, BUSY, CMD_READY, EXP_Q, MISMATCH} !== 7'b0000100) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b",
                     {J, K, DONE, BUSY, CMD_READY, EXP_Q, MISMATCH}, 7'b0000100);
        end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_single_set();
        push_one(2'b10, 4'd0);
        n_cmp++;
        if ({J, K, DONE, BUSY} !== 4'b0001) begin
            n_err++; $display("FAIL set_after_push: jkdb got %b want 0001", {J, K, DONE, BUSY});
        end
        step();
        n_cmp++;
        if ({J, K, DONE, BUSY} !== 4'b1011) begin
            n_err++; $display("FAIL set_drive: jkdb got %b want 1011", {J, K, DONE, BUSY});
        end
        step();
        n_cmp++;
        if ({J, K, DONE, BUSY, EXP_Q, MISMATCH} !== {4'b0000, CHK, 1'b0}) begin
            n_err++;
            $display("FAIL set_idle: jkdb/exp/mis got %b want %b",
                     {J, K, DONE, BUSY, EXP_Q, MISMATCH}, {4'b0000, CHK, 1'b0});
        end
        step();
        n_cmp++;
        if (MISMATCH !== 1'b0) begin
            n_err++; $display("FAIL set_compare: mismatch got %b want 0", MISMATCH);
        end
    endtask

    task automatic test_toggle();
        logic [4:0] exp_tbl;
        logic [4:0] want;
        exp_tbl = 5'b10101;
        push_one(2'b11, 4'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            want = {(i < 4) ? 2'b11 : 2'b00, i == 3, i < 4, CHK & exp_tbl[i]};
            n_cmp++;
            if ({J, K, DONE, BUSY, EXP_Q} !== want || MISMATCH !== 1'b0) begin
                n_err++;
                $display("FAIL toggle_cycle%0d: jkdbe/mis got %b/%b want %b/0",
                         i, {J, K, DONE, BUSY, EXP_Q}, MISMATCH, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]       ops  [6];
        logic [CNT_W-1:0] cnts [6];
        logic [2:0]       rec  [$];
        logic [2:0]       want [$];
        int idx, cyc, full_at, first_done, n_done;
        logic rdy;
        ops  = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10};
        cnts = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0};
        for (int c = 0; c < 6; c++)
            for (int r = 0; r <= int'(cnts[c]); r++)
                want.push_back({ops[c], r == int'(cnts[c])});

        // A long HOLD keeps the player busy while the FIFO fills.
        push_one(2'b00, 4'd15);
        step();
        idx = 0; cyc = 0; full_at = -1;
        CMD_VALID = 1'b1; CMD_OP = ops[0]; CMD_CNT = cnts[0];
        while (!(idx == 6 && !BUSY) && cyc < 100) begin
            rdy = CMD_READY;
            step();
            cyc++;
            if (idx < 6 && rdy) idx++;
            if (idx < 6) begin
                CMD_OP = ops[idx]; CMD_CNT = cnts[idx];
            end else begin
                CMD_VALID = 1'b0;
            end
            if (!CMD_READY && full_at < 0) full_at = idx;
            rec.push_back({J, K, DONE});
        end
        CMD_VALID = 1'b0;

        n_cmp++;
        if (!(idx == 6 && !BUSY)) begin
            n_err++; $display("FAIL b2b_timeout: pushed %0d busy %b want 6/0", idx, BUSY);
        end
        n_cmp++;
        if (full_at !== 4) begin
            n_err++; $display("FAIL b2b_ready_drop: accepted %0d at first not-ready, want 4", full_at);
        end

        first_done = -1;
        for (int i = 0; i < rec.size(); i++)
            if (first_done < 0 && rec[i][0]) first_done = i;
        n_cmp++;
        if (first_done < 0 || first_done + 11 >= rec.size()) begin
            n_err++; $display("FAIL b2b_length: preamble done at %0d of %0d cycles", first_done, rec.size());
        end else begin
            for (int t = 0; t < 10; t++) begin
                n_cmp++;
                if (rec[first_done + 1 + t] !== want[t]) begin
                    n_err++;
                    $display("FAIL b2b_play%0d: jkd got %b want %b", t, rec[first_done + 1 + t], want[t]);
                end
            end
            n_cmp++;
            if (rec[first_done + 11] !== 3'b000) begin
                n_err++; $display("FAIL b2b_tail_idle: jkd got %b want 000", rec[first_done + 11]);
            end
            n_done = 0;
            for (int i = first_done + 1; i < rec.size(); i++) n_done += int'(rec[i][0]);
            n_cmp++;
            if (n_done !== 6) begin
                n_err++; $display("FAIL b2b_done_count: got %0d want 6", n_done);
            end
        end
    endtask

    task automatic test_stuck_mismatch();
        q_mode = 2'd1;
        push_one(2'b01, 4'd2);
        step();
        n_cmp++;
        if ({J, K} !== 2'b01) begin
            n_err++; $display("FAIL stuck_drive: jk got %b want 01", {J, K});
        end
        step();
        n_cmp++;
        if (MISMATCH !== 1'b0 || EXP_Q !== 1'b0) begin
            n_err++; $display("FAIL stuck_first_sample: mis/exp got %b%b want 00", MISMATCH, EXP_Q);
        end
        step();
        n_cmp++;
        if (MISMATCH !== CHK) begin
            n_err++; $display("FAIL stuck_rise: mismatch got %b want %b", MISMATCH, CHK);
        end
        q_mode = 2'd0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (MISMATCH !== CHK || BUSY !== 1'b0) begin
            n_err++; $display("FAIL stuck_sticky: mis/busy got %b%b want %b0", MISMATCH, BUSY, CHK);
        end
    endtask

    task automatic test_reset_mid();
        push_one(2'b11, 4'd7);
        push_one(2'b10, 4'd0);
        push_one(2'b01, 4'd0);
        n_cmp++;
        if ({J, K, BUSY} !== 3'b111) begin
            n_err++; $display("FAIL midrst_pre: jkb got %b want 111", {J, K, BUSY});
        end
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        n_cmp++;
        if ({J, K, DONE, BUSY, CMD_READY, EXP_Q, MISMATCH} !== 7'b0000100) begin
            n_err++;
            $display("FAIL midrst_state: got %b want 0000100",
                     {J, K, DONE, BUSY, CMD_READY, EXP_Q, MISMATCH});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({J, K, DONE, BUSY} !== 4'b0000) begin
                n_err++; $display("FAIL midrst_quiet%0d: jkdb got %b want 0000", i, {J, K, DONE, BUSY});
            end
        end
    endtask

    task automatic test_unknown();
        int cyc;
        q_mode = 2'd2;
        push_one(2'b11, 4'd2);
        push_one(2'b00, 4'd1);
        push_one(2'b11, 4'd1);
        cyc = 0;
        while (BUSY && cyc < 30) begin
            n_cmp++;
            if (MISMATCH !== 1'b0) begin
                n_err++; $display("FAIL unknown_cycle%0d: mismatch got %b want 0", cyc, MISMATCH);
            end
            step();
            cyc++;
        end
        n_cmp++;
        if (BUSY !== 1'b0 || EXP_Q !== CHK || MISMATCH !== 1'b0) begin
            n_err++;
            $display("FAIL unknown_end: busy/exp/mis got %b%b%b want 0%b0", BUSY, EXP_Q, MISMATCH, CHK);
        end
        push_one(2'b10, 4'd0);
        step();
        step();
        q_mode = 2'd0;
        n_cmp++;
        if (EXP_Q !== CHK || MISMATCH !== 1'b0) begin
            n_err++; $display("FAIL unknown_set: exp/mis got %b%b want %b0", EXP_Q, MISMATCH, CHK);
        end
        step();
        n_cmp++;
        if (MISMATCH !== 1'b0) begin
            n_err++; $display("FAIL known_track: mismatch got %b want 0", MISMATCH);
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_toggle();
        test_back_to_back();
        test_stuck_mismatch();
        test_reset_mid();
        test_unknown();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
